// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem requests, registered output slot
//
// Purpose: owns the program counter and fetches from a stateless, variable-wait
// instruction memory. It holds one fetched instruction in a registered slot that
// feeds the fetch-to-decode register. It handles stall back-pressure and
// branch/jump redirects, and it traps into a sticky error state on memory timeout.
//
// Ports:
//   clock, reset      clock and asynchronous active-high reset
//   stall             downstream cannot take f_instr/f_pc this cycle
//   redirect          taken branch/jump; redirect_pc is the new PC (bits [1:0] dropped)
//   imem_req/addr     combinational request to instruction memory (addr = pc)
//   imem_rdata/ready  response word, valid when imem_req & imem_ready
//   f_instr/f_pc      output slot contents (NOP_INSTR while empty)
//   f_valid           output slot holds a real instruction
//   fetch_err         sticky memory timeout flag
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [15:0] wait_cnt_q,  wait_cnt_d;
  logic [31:0] f_instr_q,   f_instr_d;
  logic [31:0] f_pc_q,      f_pc_d;
  logic        f_valid_q,   f_valid_d;
  logic        fetch_err_q, fetch_err_d;

  logic advance;
  logic complete;
  logic waiting;
  logic timeout_hit;
  logic unused_redirect_lsbs;

  // Low PC bits of a redirect target are discarded, instructions are word aligned.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The slot can take a new instruction when it is empty or being consumed now.
  assign advance     = !f_valid_q || !stall;
  assign imem_req    = (state_q == ST_RUN) && advance && !redirect;
  assign imem_addr   = pc_q;
  assign complete    = imem_req && imem_ready;
  assign waiting     = imem_req && !imem_ready;
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wait_cnt_d  = wait_cnt_q;
    f_instr_d   = f_instr_q;
    f_pc_d      = f_pc_q;
    f_valid_d   = f_valid_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect) begin
          pc_d       = {redirect_pc[31:2], 2'b00};
          f_valid_d  = 1'b0;
          f_instr_d  = NOP_INSTR;
          wait_cnt_d = '0;
        end else if (complete) begin
          // A completion also refills a slot that is being consumed this cycle.
          f_instr_d  = imem_rdata;
          f_pc_d     = pc_q;
          f_valid_d  = 1'b1;
          pc_d       = pc_q + 32'd4;
          wait_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d     = ST_ERROR;
          fetch_err_d = 1'b1;
          f_valid_d   = 1'b0;
          f_instr_d   = NOP_INSTR;
        end else begin
          if (waiting) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
          if (f_valid_q && !stall) begin
            f_valid_d = 1'b0;
            f_instr_d = NOP_INSTR;
          end
        end
      end

      ST_ERROR: begin
        // Terminal until reset; everything holds.
      end

      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      wait_cnt_q  <= '0;
      f_instr_q   <= NOP_INSTR;
      f_pc_q      <= '0;
      f_valid_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wait_cnt_q  <= wait_cnt_d;
      f_instr_q   <= f_instr_d;
      f_pc_q      <= f_pc_d;
      f_valid_q   <= f_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign f_instr   = f_instr_q;
  assign f_pc      = f_pc_q;
  assign f_valid   = f_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .f_instr    (f_instr),
    .f_pc       (f_pc),
    .f_valid    (f_valid),
    .fetch_err  (fetch_err)
  );

  // Stateless memory: the word at an address is the address xor K.
  assign imem_rdata = imem_addr ^ K;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    cyc(); cyc();
    #1;
    check("rst_req",   {31'd0, imem_req},  32'd0);
    check("rst_addr",  imem_addr,          32'h100);
    check("rst_instr", f_instr,            32'h0);
    check("rst_pc",    f_pc,               32'h0);
    check("rst_valid", {31'd0, f_valid},   32'd0);
    check("rst_err",   {31'd0, fetch_err}, 32'd0);

    // Boot cycle, then zero-wait streaming.
    cyc();
    reset = 1'b0;
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    cyc(); #1;
    check("run_req",  {31'd0, imem_req}, 32'd1);
    check("run_addr0", imem_addr, 32'h100);
    check("run_valid0", {31'd0, f_valid}, 32'd0);
    cyc(); #1;
    check("s1_fpc",   f_pc,    32'h100);
    check("s1_instr", f_instr, 32'h100 ^ K);
    check("s1_valid", {31'd0, f_valid}, 32'd1);
    check("s1_addr",  imem_addr, 32'h104);
    cyc(); #1;
    check("s2_fpc",  f_pc,      32'h104);
    check("s2_addr", imem_addr, 32'h108);
    cyc(); #1;
    check("s3_fpc",  f_pc,      32'h108);
    check("s3_addr", imem_addr, 32'h10C);

    // Stall holds the slot and suppresses requests.
    stall = 1'b1;
    #1;
    check("stall_req0", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check("stall_req",   {31'd0, imem_req}, 32'd0);
      check("stall_fpc",   f_pc,    32'h108);
      check("stall_instr", f_instr, 32'h108 ^ K);
    end
    stall = 1'b0;
    #1;
    check("unstall_req",  {31'd0, imem_req}, 32'd1);
    check("unstall_addr", imem_addr, 32'h10C);
    cyc(); #1;
    check("unstall_fpc",   f_pc, 32'h10C);
    check("unstall_valid", {31'd0, f_valid}, 32'd1);

    // Two waits, then a redirect, which must clear the wait counter.
    imem_ready = 1'b0;
    #1;
    check("w_addr", imem_addr, 32'h110);
    cyc(); #1;
    check("w_consumed", {31'd0, f_valid}, 32'd0);
    check("w_instr_nop", f_instr, 32'h0);
    check("w_fpc_hold", f_pc, 32'h10C);
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    #1;
    check("redir_req", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    check("redir_addr",  imem_addr, 32'h200);
    check("redir_req1",  {31'd0, imem_req}, 32'd1);
    check("redir_valid", {31'd0, f_valid}, 32'd0);
    cyc(); cyc(); cyc();
    imem_ready = 1'b1;
    #1;
    check("w3_err", {31'd0, fetch_err}, 32'd0);
    check("w3_req", {31'd0, imem_req}, 32'd1);
    cyc(); #1;
    check("w3_fpc",   f_pc, 32'h200);
    check("w3_valid", {31'd0, f_valid}, 32'd1);
    check("w3_err2",  {31'd0, fetch_err}, 32'd0);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    check("wrap_fpc",  f_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Timeout after four waiting request cycles.
    imem_ready = 1'b0;
    cyc(); cyc(); cyc(); #1;
    check("to_pre_err", {31'd0, fetch_err}, 32'd0);
    check("to_pre_req", {31'd0, imem_req}, 32'd1);
    cyc(); #1;
    check("to_err",   {31'd0, fetch_err}, 32'd1);
    check("to_req",   {31'd0, imem_req}, 32'd0);
    check("to_valid", {31'd0, f_valid}, 32'd0);
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0400;
    #1;
    check("err_req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;
    check("err_sticky", {31'd0, fetch_err}, 32'd1);
    check("err_addr",   imem_addr, 32'h0);
    redirect = 1'b0;

    // Async reset from ERROR, then reset in the middle of a wait.
    #2 reset = 1'b1;
    #1;
    check("ar_err",  {31'd0, fetch_err}, 32'd0);
    check("ar_addr", imem_addr, 32'h100);
    cyc();
    reset = 1'b0; imem_ready = 1'b0;
    cyc(); #1;
    check("mw_req", {31'd0, imem_req}, 32'd1);
    cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    check("mw_rst_req",   {31'd0, imem_req}, 32'd0);
    check("mw_rst_addr",  imem_addr, 32'h100);
    check("mw_rst_valid", {31'd0, f_valid}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    imem_ready = 1'b1;
    cyc(); #1;
    check("mw_after_err", {31'd0, fetch_err}, 32'd0);
    check("mw_after_fpc", f_pc, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
